gumnut_fetch_unit: RTL and testbench

Instruction-fetch stage of the Gumnut core, directly upstream of the control unit. It owns the program counter and the 8-entry return-address stack, and runs instruction-bus cycles on request. It latches the fetched 18-bit word into the instruction register and presents the opcode and subfunction fields that the control unit decodes. It also applies the PC update the control unit selects after each instruction.

---
 rtl/gumnut_pkg.sv | 43 ++++
 rtl/gumnut_ret_stack.sv | 64 ++++++
 rtl/gumnut_fetch_unit.sv | 124 ++++++++++++
 tb/tb_gumnut_fetch_unit.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gumnut_pkg.sv
// Shared types and constants for the Gumnut fetch stage: PC operations,
// fetch FSM states, opcode prefixes and the subfunction decoder.
package gumnut_pkg;

  localparam logic [11:0] INT_VECTOR_DEFAULT = 12'h001;

  typedef enum logic [3:0] {
    PC_HOLD = 4'd0,
    PC_INC  = 4'd1,
    PC_BR   = 4'd2,
    PC_JMP  = 4'd3,
    PC_JSB  = 4'd4,
    PC_RET  = 4'd5,
    PC_INT  = 4'd6,
    PC_RETI = 4'd7
  } pc_op_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } fetch_state_t;

  localparam logic [1:0] PFX_MEM    = 2'b10;
  localparam logic [2:0] PFX_ALUREG = 3'b110;
  localparam logic [5:0] PFX_BRANCH = 6'b111110;
  localparam logic [4:0] PFX_JUMP   = 5'b11110;
  localparam logic [6:0] PFX_MISC   = 7'b1111110;

  // Prefixes are checked longest-first within each ambiguous group; branch and
  // jump differ at IR[13], so their relative order does not matter.
  function automatic logic [2:0] decode_func(input logic [17:0] ir);
    logic [2:0] f;
    f = '0;
    if (!ir[17])                        f = ir[16:14];
    else if (ir[17:16] == PFX_MEM)      f = {1'b0, ir[15:14]};
    else if (ir[17:15] == PFX_ALUREG)   f = ir[2:0];
    else if (ir[17:12] == PFX_BRANCH)   f = {1'b0, ir[11:10]};
    else if (ir[17:13] == PFX_JUMP)     f = {2'b0, ir[12]};
    else if (ir[17:11] == PFX_MISC)     f = ir[10:8];
    return f;
  endfunction

endpackage

// File: rtl/gumnut_ret_stack.sv
// Circular return-address stack. Overflow overwrites the oldest entry and
// underflow returns stale data; both raise a sticky error flag.
module gumnut_ret_stack
  import gumnut_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [AW-1:0] push_data_i,
  output logic [AW-1:0] pop_data_o,
  output logic          err_o
);

  localparam int unsigned SPW  = $clog2(DEPTH);
  localparam int unsigned CNTW = SPW + 1;

  logic [AW-1:0]   mem_q [DEPTH];
  logic [SPW-1:0]  sp_q, sp_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            err_q, err_d;

  always_comb begin
    sp_d  = sp_q;
    cnt_d = cnt_q;
    err_d = err_q;
    if (push_i) begin
      sp_d = sp_q + SPW'(1);
      if (cnt_q == CNTW'(DEPTH)) err_d = 1'b1;
      else                       cnt_d = cnt_q + CNTW'(1);
    end else if (pop_i) begin
      // Underflow leaves the pointer alone so the stale slot stays stable.
      if (cnt_q == '0) begin
        err_d = 1'b1;
      end else begin
        sp_d  = sp_q - SPW'(1);
        cnt_d = cnt_q - CNTW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q  <= '0;
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_i) mem_q[sp_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[sp_q - SPW'(1)];
  assign err_o      = err_q;

endmodule

// File: rtl/gumnut_fetch_unit.sv
// Gumnut instruction-fetch stage: PC, instruction register, bus fetch FSM
// and PC update sequencing with the return-address stack.
module gumnut_fetch_unit
  import gumnut_pkg::*;
#(
  parameter int unsigned        IMEM_AW     = 12,
  parameter int unsigned        STACK_DEPTH = 8,
  parameter logic [IMEM_AW-1:0] INT_VECTOR  = IMEM_AW'(INT_VECTOR_DEFAULT)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req_i,
  output logic               inst_cyc_o,
  output logic               inst_stb_o,
  output logic [IMEM_AW-1:0] inst_adr_o,
  input  logic [17:0]        inst_dat_i,
  input  logic               inst_ack_i,
  output logic               inst_valid_o,
  output logic [6:0]         op_o,
  output logic [2:0]         func_o,
  output logic [17:0]        ir_o,
  output logic [IMEM_AW-1:0] pc_o,
  input  logic               pc_upd_i,
  input  logic [3:0]         pc_op_i,
  input  logic               br_taken_i,
  output logic               stack_err_o
);

  fetch_state_t       state_q, state_d;
  logic [IMEM_AW-1:0] pc_q, pc_d;
  logic [17:0]        ir_q, ir_d;
  logic               valid_q, valid_d;

  logic               push, pop;
  logic [IMEM_AW-1:0] push_data, pop_data;
  logic [IMEM_AW-1:0] pc_inc, br_off;
  pc_op_t             op;

  assign op     = pc_op_t'(pc_op_i);
  assign pc_inc = pc_q + IMEM_AW'(1);
  assign br_off = {{(IMEM_AW-8){ir_q[7]}}, ir_q[7:0]};

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    valid_d = 1'b0;
    unique case (state_q)
      ST_IDLE: if (fetch_req_i) state_d = ST_BUS;
      ST_BUS: begin
        if (inst_ack_i) begin
          state_d = ST_IDLE;
          ir_d    = inst_dat_i;
          valid_d = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    push      = 1'b0;
    pop       = 1'b0;
    push_data = pc_inc;
    if (pc_upd_i) begin
      case (op)
        PC_INC: pc_d = pc_inc;
        PC_BR:  pc_d = br_taken_i ? pc_inc + br_off : pc_inc;
        PC_JMP: pc_d = ir_q[IMEM_AW-1:0];
        PC_JSB: begin
          push = 1'b1;
          pc_d = ir_q[IMEM_AW-1:0];
        end
        PC_RET, PC_RETI: begin
          pop  = 1'b1;
          pc_d = pop_data;
        end
        PC_INT: begin
          push      = 1'b1;
          push_data = pc_q;
          pc_d      = INT_VECTOR;
        end
        default: pc_d = pc_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      ir_q    <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      valid_q <= valid_d;
    end
  end

  gumnut_ret_stack #(
    .DEPTH (STACK_DEPTH),
    .AW    (IMEM_AW)
  ) u_stack (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .push_data_i (push_data),
    .pop_data_o  (pop_data),
    .err_o       (stack_err_o)
  );

  assign inst_cyc_o   = (state_q == ST_BUS);
  assign inst_stb_o   = (state_q == ST_BUS);
  assign inst_adr_o   = pc_q;
  assign inst_valid_o = valid_q;
  assign ir_o         = ir_q;
  assign op_o         = ir_q[17:11];
  assign func_o       = decode_func(ir_q);
  assign pc_o         = pc_q;

endmodule

// File: tb/tb_gumnut_fetch_unit.sv
// Scoreboard bench for gumnut_fetch_unit: fetched words are queued when driven
// and checked when inst_valid_o fires; PC/stack behaviour follows a small model.
module tb_gumnut_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req_i;
  logic        inst_cyc_o, inst_stb_o;
  logic [11:0] inst_adr_o;
  logic [17:0] inst_dat_i;
  logic        inst_ack_i;
  logic        inst_valid_o;
  logic [6:0]  op_o;
  logic [2:0]  func_o;
  logic [17:0] ir_o;
  logic [11:0] pc_o;
  logic        pc_upd_i;
  logic [3:0]  pc_op_i;
  logic        br_taken_i;
  logic        stack_err_o;

  gumnut_fetch_unit #(
    .IMEM_AW     (12),
    .STACK_DEPTH (8),
    .INT_VECTOR  (12'h001)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req_i  (fetch_req_i),
    .inst_cyc_o   (inst_cyc_o),
    .inst_stb_o   (inst_stb_o),
    .inst_adr_o   (inst_adr_o),
    .inst_dat_i   (inst_dat_i),
    .inst_ack_i   (inst_ack_i),
    .inst_valid_o (inst_valid_o),
    .op_o         (op_o),
    .func_o       (func_o),
    .ir_o         (ir_o),
    .pc_o         (pc_o),
    .pc_upd_i     (pc_upd_i),
    .pc_op_i      (pc_op_i),
    .br_taken_i   (br_taken_i),
    .stack_err_o  (stack_err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [17:0] ir;
    logic [11:0] pc;
  } fexp_t;

  fexp_t       sb_q[$];
  logic [11:0] m_stk[$];
  logic [11:0] m_pc;
  logic [17:0] m_ir;
  logic        m_err;
  int          vectors    = 0;
  int          miscompares = 0;
  int          valid_cnt  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] ref_func(input logic [17:0] ir);
    casez (ir[17:11])
      7'b0??????: ref_func = ir[16:14];
      7'b10?????: ref_func = {1'b0, ir[15:14]};
      7'b110????: ref_func = ir[2:0];
      7'b111110?: ref_func = {1'b0, ir[11:10]};
      7'b11110??: ref_func = {2'b0, ir[12]};
      7'b1111110: ref_func = ir[10:8];
      default:    ref_func = 3'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n && inst_valid_o) begin
      fexp_t e;
      valid_cnt++;
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_valid", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        chk("sb_ir",   32'(ir_o),   32'(e.ir));
        chk("sb_op",   32'(op_o),   32'(e.ir[17:11]));
        chk("sb_func", 32'(func_o), 32'(ref_func(e.ir)));
        chk("sb_pc",   32'(pc_o),   32'(e.pc));
      end
    end
    if (rst_n && pc_upd_i && inst_cyc_o)
      chk("proto_pc_upd_in_bus", 32'(1), 32'(0));
  end

  task automatic fetch(input logic [17:0] dat, input int waits, input int drop_after);
    int v0;
    v0 = valid_cnt;
    sb_q.push_back('{ir: dat, pc: m_pc});
    fetch_req_i = 1'b1;
    inst_dat_i  = dat;
    for (int k = 0; k <= waits; k++) begin
      @(posedge clk); #1;
      chk("bus_cyc", 32'(inst_cyc_o), 32'(1));
      chk("bus_stb", 32'(inst_stb_o), 32'(1));
      chk("bus_adr", 32'(inst_adr_o), 32'(m_pc));
      if (k + 1 == drop_after) fetch_req_i = 1'b0;
      if (k == waits) inst_ack_i = 1'b1;
    end
    @(posedge clk); #1;
    inst_ack_i  = 1'b0;
    fetch_req_i = 1'b0;
    chk("valid_pulse", 32'(inst_valid_o), 32'(1));
    chk("cyc_drop",    32'(inst_cyc_o),   32'(0));
    @(posedge clk); #1;
    chk("valid_low", 32'(inst_valid_o), 32'(0));
    chk("valid_cnt", 32'(valid_cnt - v0), 32'(1));
    m_ir = dat;
  endtask

  task automatic pc_step(input logic [3:0] op, input logic br, input logic check_pc);
    logic [11:0] exp;
    exp = m_pc;
    case (op)
      4'd1: exp = m_pc + 12'd1;
      4'd2: exp = br ? m_pc + 12'd1 + {{4{m_ir[7]}}, m_ir[7:0]} : m_pc + 12'd1;
      4'd3: exp = m_ir[11:0];
      4'd4, 4'd6: begin
        if (m_stk.size() == 8) begin
          void'(m_stk.pop_front());
          m_err = 1'b1;
        end
        m_stk.push_back(op == 4'd4 ? m_pc + 12'd1 : m_pc);
        exp = (op == 4'd4) ? m_ir[11:0] : 12'h001;
      end
      4'd5, 4'd7: begin
        if (m_stk.size() == 0) m_err = 1'b1;
        else                   exp = m_stk.pop_back();
      end
      default: exp = m_pc;
    endcase
    pc_upd_i   = 1'b1;
    pc_op_i    = op;
    br_taken_i = br;
    @(posedge clk); #1;
    pc_upd_i   = 1'b0;
    pc_op_i    = 4'd0;
    br_taken_i = 1'b0;
    if (check_pc) chk("pc_update", 32'(pc_o), 32'(exp));
    chk("stack_err", 32'(stack_err_o), 32'(m_err));
    m_pc = exp;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running, expected done");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    rst_n = 1'b0; fetch_req_i = 1'b0; inst_dat_i = '0; inst_ack_i = 1'b0;
    pc_upd_i = 1'b0; pc_op_i = '0; br_taken_i = 1'b0;
    m_pc = '0; m_ir = '0; m_err = 1'b0;
    #12;
    chk("rst_pc",    32'(pc_o),         32'(0));
    chk("rst_ir",    32'(ir_o),         32'(0));
    chk("rst_cyc",   32'(inst_cyc_o),   32'(0));
    chk("rst_stb",   32'(inst_stb_o),   32'(0));
    chk("rst_valid", 32'(inst_valid_o), 32'(0));
    chk("rst_err",   32'(stack_err_o),  32'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Zero-wait fetch, then a 3-wait fetch with the request dropped early.
    fetch(18'h0C005, 0, 0);
    fetch(18'h1234A, 3, 1);
    // Decoder coverage across instruction classes.
    fetch(18'h3000D, 1, 0);
    fetch(18'h24000, 0, 0);
    fetch(18'h3F300, 0, 0);
    pc_step(4'd9, 1'b0, 1'b1);

    // Branch backwards taken / not taken.
    fetch(18'h3C010, 0, 0);
    pc_step(4'd3, 1'b0, 1'b1);
    fetch(18'h3E0FE, 2, 0);
    pc_step(4'd2, 1'b1, 1'b1);
    pc_step(4'd1, 1'b0, 1'b1);
    pc_step(4'd2, 1'b0, 1'b1);

    // PC wrap at the top of the address space.
    fetch(18'h3CFFF, 0, 0);
    pc_step(4'd3, 1'b0, 1'b1);
    pc_step(4'd1, 1'b0, 1'b1);

    // Subroutine call/return and interrupt/return.
    fetch(18'h3C020, 0, 0);
    pc_step(4'd3, 1'b0, 1'b1);
    fetch(18'h3D100, 0, 0);
    pc_step(4'd4, 1'b0, 1'b1);
    pc_step(4'd5, 1'b0, 1'b1);
    fetch(18'h3C050, 0, 0);
    pc_step(4'd3, 1'b0, 1'b1);
    pc_step(4'd6, 1'b0, 1'b1);
    pc_step(4'd7, 1'b0, 1'b1);

    // Nine nested calls overflow the stack; eight returns unwind it.
    fetch(18'h3D100, 0, 0);
    for (int i = 0; i < 9; i++) begin
      for (int j = 0; j < i; j++) pc_step(4'd1, 1'b0, 1'b1);
      pc_step(4'd4, 1'b0, 1'b1);
    end
    for (int i = 0; i < 8; i++) pc_step(4'd5, 1'b0, 1'b1);
    pc_step(4'd5, 1'b0, 1'b0);

    // Reset in the middle of a bus cycle with an ack arriving during reset.
    v0 = valid_cnt;
    fetch_req_i = 1'b1;
    inst_dat_i  = 18'h3FFFF;
    @(posedge clk); #1;
    chk("mid_bus_cyc", 32'(inst_cyc_o), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("async_rst_cyc", 32'(inst_cyc_o), 32'(0));
    chk("async_rst_stb", 32'(inst_stb_o), 32'(0));
    inst_ack_i = 1'b1;
    @(posedge clk); #1;
    inst_ack_i  = 1'b0;
    fetch_req_i = 1'b0;
    rst_n = 1'b1;
    m_pc = '0; m_ir = '0; m_err = 1'b0; m_stk.delete();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst2_ir",    32'(ir_o),              32'(0));
    chk("rst2_pc",    32'(pc_o),              32'(0));
    chk("rst2_err",   32'(stack_err_o),       32'(0));
    chk("rst2_cyc",   32'(inst_cyc_o),        32'(0));
    chk("rst2_valid", 32'(valid_cnt - v0),    32'(0));

    fetch(18'h0C005, 0, 0);
    chk("sb_drained", 32'(sb_q.size()), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
